// File: rtl/pipe_front_ctrl.sv
// Front-end pipeline registers (PC, IF/ID, ID/EX control/RT) steered by the
// load-use hazard detector, plus stall-cycle accounting and a runaway-stall flag.
module pipe_front_ctrl #(
  parameter int                 N_BITS      = 32,
  parameter logic [N_BITS-1:0]  RESET_PC    = 32'h0040_0000,
  parameter int                 CTRL_W      = 12,
  parameter int                 MEMREAD_BIT = 3,
  parameter int                 MAX_STALL   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              DWrite,
  input  logic              Bubble,
  input  logic              Flush,
  input  logic [N_BITS-1:0] NextPC,
  input  logic [N_BITS-1:0] Instruction_IF,
  input  logic [CTRL_W-1:0] Ctrl_ID,
  input  logic [4:0]        RT_ID,
  output logic [N_BITS-1:0] PC,
  output logic [N_BITS-1:0] Instruction_ID,
  output logic [N_BITS-1:0] PCPlus4_ID,
  output logic              Valid_ID,
  output logic [CTRL_W-1:0] Ctrl_EX,
  output logic [4:0]        RT_EX,
  output logic              MemRead_EX,
  output logic [15:0]       StallCount,
  output logic              StallErr
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  logic [N_BITS-1:0] pc_q, pc_d;
  logic [N_BITS-1:0] instr_q, instr_d;
  logic [N_BITS-1:0] pcp4_q, pcp4_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [4:0]        rt_q, rt_d;
  logic              stall_s;

  state_e            state_q;
  logic [2:0]        run_cnt_q;
  logic [15:0]       stall_cnt_q;
  logic              stall_err_q;

  // Next-state selection for the PC, IF/ID and ID/EX registers.
  always_comb begin
    stall_s = ~Flush & ~PCWrite;

    if (Flush) begin
      pc_d = NextPC;
    end else if (PCWrite) begin
      pc_d = NextPC;
    end else begin
      pc_d = pc_q;
    end

    if (Flush) begin
      instr_d = {N_BITS{1'b0}};
      pcp4_d  = {N_BITS{1'b0}};
      valid_d = 1'b0;
    end else if (DWrite) begin
      instr_d = Instruction_IF;
      pcp4_d  = pc_q + N_BITS'(3'd4);
      valid_d = 1'b1;
    end else begin
      instr_d = instr_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
    end

    // An empty IF/ID slot must not issue control, same as an explicit bubble.
    if (Bubble || !valid_q) begin
      ctrl_d = {CTRL_W{1'b0}};
    end else begin
      ctrl_d = Ctrl_ID;
    end

    rt_d = RT_ID;
  end

  // Pipeline register bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= {N_BITS{1'b0}};
      pcp4_q  <= {N_BITS{1'b0}};
      valid_q <= 1'b0;
      ctrl_q  <= {CTRL_W{1'b0}};
      rt_q    <= 5'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rt_q    <= rt_d;
    end
  end

  // Stall tracking FSM with consecutive-run counter, total counter and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      run_cnt_q   <= 3'd0;
      stall_cnt_q <= 16'd0;
      stall_err_q <= 1'b0;
    end else begin
      if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end

      case (state_q)
        ST_RUN: begin
          if (stall_s) begin
            state_q   <= ST_STALL;
            run_cnt_q <= 3'd1;
          end else begin
            state_q   <= ST_RUN;
            run_cnt_q <= 3'd0;
          end
          stall_err_q <= stall_err_q;
        end
        ST_STALL: begin
          if (stall_s) begin
            state_q <= ST_STALL;
            if (run_cnt_q != 3'd7) begin
              run_cnt_q <= run_cnt_q + 3'd1;
            end else begin
              run_cnt_q <= run_cnt_q;
            end
            // One stall beyond the legal run length trips the flag.
            if (run_cnt_q >= 3'(MAX_STALL)) begin
              stall_err_q <= 1'b1;
            end else begin
              stall_err_q <= stall_err_q;
            end
          end else begin
            state_q     <= ST_RUN;
            run_cnt_q   <= 3'd0;
            stall_err_q <= stall_err_q;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          run_cnt_q   <= 3'd0;
          stall_err_q <= stall_err_q;
        end
      endcase
    end
  end

  assign PC             = pc_q;
  assign Instruction_ID = instr_q;
  assign PCPlus4_ID     = pcp4_q;
  assign Valid_ID       = valid_q;
  assign Ctrl_EX        = ctrl_q;
  assign RT_EX          = rt_q;
  assign MemRead_EX     = ctrl_q[MEMREAD_BIT];
  assign StallCount     = stall_cnt_q;
  assign StallErr       = stall_err_q;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Scenario bench for pipe_front_ctrl: expected values are queued as stimulus is
// driven and popped for comparison once the clock edge has taken effect.
module tb_pipe_front_ctrl;

  logic        clk;
  logic        reset;
  logic        PCWrite, DWrite, Bubble, Flush;
  logic [31:0] NextPC, Instruction_IF;
  logic [11:0] Ctrl_ID;
  logic [4:0]  RT_ID;
  logic [31:0] PC, Instruction_ID, PCPlus4_ID;
  logic        Valid_ID;
  logic [11:0] Ctrl_EX;
  logic [4:0]  RT_EX;
  logic        MemRead_EX;
  logic [15:0] StallCount;
  logic        StallErr;

  logic [31:0] sb[$];
  logic [31:0] exp;
  int          n_cmp  = 0;
  int          n_fail = 0;

  pipe_front_ctrl dut (
    .clk(clk), .reset(reset),
    .PCWrite(PCWrite), .DWrite(DWrite), .Bubble(Bubble), .Flush(Flush),
    .NextPC(NextPC), .Instruction_IF(Instruction_IF),
    .Ctrl_ID(Ctrl_ID), .RT_ID(RT_ID),
    .PC(PC), .Instruction_ID(Instruction_ID), .PCPlus4_ID(PCPlus4_ID),
    .Valid_ID(Valid_ID), .Ctrl_EX(Ctrl_EX), .RT_EX(RT_EX),
    .MemRead_EX(MemRead_EX), .StallCount(StallCount), .StallErr(StallErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pcw, input logic dw, input logic bub, input logic fl,
                       input logic [31:0] npc, input logic [31:0] ins,
                       input logic [11:0] ctl, input logic [4:0] rt);
    PCWrite = pcw; DWrite = dw; Bubble = bub; Flush = fl;
    NextPC = npc; Instruction_IF = ins; Ctrl_ID = ctl; RT_ID = rt;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 12'h0, 5'd0);
    #23;
    sb.push_back(32'h0040_0000); sb.push_back(32'h0); sb.push_back(32'h0);
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL rst_pc got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (Valid_ID !== exp[0]) begin n_fail++; $display("FAIL rst_valid got %b want %b", Valid_ID, exp[0]); end
    exp = sb.pop_front(); n_cmp++; if (Ctrl_EX !== exp[11:0]) begin n_fail++; $display("FAIL rst_ctrl got %h want %h", Ctrl_EX, exp[11:0]); end
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0004, 32'h1234_5678, 12'h0, 5'd0);
    sb.push_back(32'h0040_0004); sb.push_back(32'h1); sb.push_back(32'h0040_0004); sb.push_back(32'h1234_5678);
    step();
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL run_pc got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (Valid_ID !== exp[0]) begin n_fail++; $display("FAIL run_valid got %b want %b", Valid_ID, exp[0]); end
    exp = sb.pop_front(); n_cmp++; if (PCPlus4_ID !== exp) begin n_fail++; $display("FAIL run_pcp4 got %h want %h", PCPlus4_ID, exp); end
    exp = sb.pop_front(); n_cmp++; if (Instruction_ID !== exp) begin n_fail++; $display("FAIL run_instr got %h want %h", Instruction_ID, exp); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0008, 32'hAAAA_0001, 12'h00A, 5'd3);
    sb.push_back(32'h00A); sb.push_back(32'h1);
    step();
    exp = sb.pop_front(); n_cmp++; if (Ctrl_EX !== exp[11:0]) begin n_fail++; $display("FAIL lu_ctrl_pass got %h want %h", Ctrl_EX, exp[11:0]); end
    exp = sb.pop_front(); n_cmp++; if (MemRead_EX !== exp[0]) begin n_fail++; $display("FAIL lu_memrd_pass got %b want %b", MemRead_EX, exp[0]); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_000C, 32'hBBBB_0002, 12'h00A, 5'd7);
    sb.push_back(32'h0040_0008); sb.push_back(32'hAAAA_0001); sb.push_back(32'h0);
    sb.push_back(32'h0); sb.push_back(32'd1); sb.push_back(32'd7);
    step();
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL lu_pc_hold got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (Instruction_ID !== exp) begin n_fail++; $display("FAIL lu_instr_hold got %h want %h", Instruction_ID, exp); end
    exp = sb.pop_front(); n_cmp++; if (Ctrl_EX !== exp[11:0]) begin n_fail++; $display("FAIL lu_bubble got %h want %h", Ctrl_EX, exp[11:0]); end
    exp = sb.pop_front(); n_cmp++; if (MemRead_EX !== exp[0]) begin n_fail++; $display("FAIL lu_memrd got %b want %b", MemRead_EX, exp[0]); end
    exp = sb.pop_front(); n_cmp++; if (StallCount !== exp[15:0]) begin n_fail++; $display("FAIL lu_cnt got %0d want %0d", StallCount, exp[15:0]); end
    exp = sb.pop_front(); n_cmp++; if (RT_EX !== exp[4:0]) begin n_fail++; $display("FAIL lu_rt got %0d want %0d", RT_EX, exp[4:0]); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_000C, 32'hCCCC_0003, 12'h00A, 5'd4);
    sb.push_back(32'h0040_000C); sb.push_back(32'h00A); sb.push_back(32'd1);
    step();
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL lu_resume_pc got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (Ctrl_EX !== exp[11:0]) begin n_fail++; $display("FAIL lu_resume_ctrl got %h want %h", Ctrl_EX, exp[11:0]); end
    exp = sb.pop_front(); n_cmp++; if (StallCount !== exp[15:0]) begin n_fail++; $display("FAIL lu_resume_cnt got %0d want %0d", StallCount, exp[15:0]); end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100, 32'hEEEE_0005, 12'h0FF, 5'd2);
    sb.push_back(32'h0040_0100); sb.push_back(32'h0); sb.push_back(32'h0);
    sb.push_back(32'h0); sb.push_back(32'd1);
    step();
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL fl_pc got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (Instruction_ID !== exp) begin n_fail++; $display("FAIL fl_instr got %h want %h", Instruction_ID, exp); end
    exp = sb.pop_front(); n_cmp++; if (PCPlus4_ID !== exp) begin n_fail++; $display("FAIL fl_pcp4 got %h want %h", PCPlus4_ID, exp); end
    exp = sb.pop_front(); n_cmp++; if (Valid_ID !== exp[0]) begin n_fail++; $display("FAIL fl_valid got %b want %b", Valid_ID, exp[0]); end
    exp = sb.pop_front(); n_cmp++; if (StallCount !== exp[15:0]) begin n_fail++; $display("FAIL fl_cnt got %0d want %0d", StallCount, exp[15:0]); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0104, 32'hDDDD_0004, 12'h0FF, 5'd2);
    sb.push_back(32'h0); sb.push_back(32'h1); sb.push_back(32'h0040_0104);
    step();
    exp = sb.pop_front(); n_cmp++; if (Ctrl_EX !== exp[11:0]) begin n_fail++; $display("FAIL fl_invalid_ctrl got %h want %h", Ctrl_EX, exp[11:0]); end
    exp = sb.pop_front(); n_cmp++; if (Valid_ID !== exp[0]) begin n_fail++; $display("FAIL fl_refill_valid got %b want %b", Valid_ID, exp[0]); end
    exp = sb.pop_front(); n_cmp++; if (PCPlus4_ID !== exp) begin n_fail++; $display("FAIL fl_refill_pcp4 got %h want %h", PCPlus4_ID, exp); end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0200, 32'h7777_0007, 12'h0FF, 5'd2);
    sb.push_back(32'h0040_0200); sb.push_back(32'h0); sb.push_back(32'h0);
    step();
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL flb_pc got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (Valid_ID !== exp[0]) begin n_fail++; $display("FAIL flb_valid got %b want %b", Valid_ID, exp[0]); end
    exp = sb.pop_front(); n_cmp++; if (Ctrl_EX !== exp[11:0]) begin n_fail++; $display("FAIL flb_ctrl got %h want %h", Ctrl_EX, exp[11:0]); end
  endtask

  task automatic test_runaway();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0300, 32'h0, 12'h00A, 5'd1);
    for (int i = 1; i <= 5; i++) begin
      sb.push_back((i == 5) ? 32'h1 : 32'h0);
      step();
      exp = sb.pop_front(); n_cmp++; if (StallErr !== exp[0]) begin n_fail++; $display("FAIL rs_err_edge%0d got %b want %b", i, StallErr, exp[0]); end
    end
    sb.push_back(32'd5);
    exp = sb.pop_front(); n_cmp++; if (StallCount !== exp[15:0]) begin n_fail++; $display("FAIL rs_cnt got %0d want %0d", StallCount, exp[15:0]); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0300, 32'h1111_0000, 12'h0, 5'd1);
    repeat (10) step();
    sb.push_back(32'h1); sb.push_back(32'd5);
    exp = sb.pop_front(); n_cmp++; if (StallErr !== exp[0]) begin n_fail++; $display("FAIL rs_sticky got %b want %b", StallErr, exp[0]); end
    exp = sb.pop_front(); n_cmp++; if (StallCount !== exp[15:0]) begin n_fail++; $display("FAIL rs_cnt_run got %0d want %0d", StallCount, exp[15:0]); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0300, 32'h5A5A_5A5A, 12'h0, 5'd0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0400, 32'h0, 12'h0, 5'd0);
    sb.push_back(32'hFFFF); sb.push_back(32'h0040_0300); sb.push_back(32'h5A5A_5A5A);
    repeat (65540) step();
    exp = sb.pop_front(); n_cmp++; if (StallCount !== exp[15:0]) begin n_fail++; $display("FAIL sat_cnt got %h want %h", StallCount, exp[15:0]); end
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL sat_pc_hold got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (Instruction_ID !== exp) begin n_fail++; $display("FAIL sat_instr_hold got %h want %h", Instruction_ID, exp); end
    sb.push_back(32'hFFFF);
    step();
    exp = sb.pop_front(); n_cmp++; if (StallCount !== exp[15:0]) begin n_fail++; $display("FAIL sat_hold got %h want %h", StallCount, exp[15:0]); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h9999_9999, 12'h0, 5'd0);
    sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h5A5A_5A5A);
    step();
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL sat_pc_top got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (Instruction_ID !== exp) begin n_fail++; $display("FAIL pcw_only_instr got %h want %h", Instruction_ID, exp); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0BAD_0000, 12'h0, 5'd0);
    sb.push_back(32'h0); sb.push_back(32'h0BAD_0000); sb.push_back(32'h0);
    step();
    exp = sb.pop_front(); n_cmp++; if (PCPlus4_ID !== exp) begin n_fail++; $display("FAIL wrap_pcp4 got %h want %h", PCPlus4_ID, exp); end
    exp = sb.pop_front(); n_cmp++; if (Instruction_ID !== exp) begin n_fail++; $display("FAIL wrap_instr got %h want %h", Instruction_ID, exp); end
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL wrap_pc got %h want %h", PC, exp); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 12'h00A, 5'd9);
    repeat (2) step();
    sb.push_back(32'h00A);
    exp = sb.pop_front(); n_cmp++; if (Ctrl_EX !== exp[11:0]) begin n_fail++; $display("FAIL ar_pre_ctrl got %h want %h", Ctrl_EX, exp[11:0]); end
    #2 reset = 1'b0;
    #1;
    sb.push_back(32'h0040_0000); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL ar_pc got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (Instruction_ID !== exp) begin n_fail++; $display("FAIL ar_instr got %h want %h", Instruction_ID, exp); end
    exp = sb.pop_front(); n_cmp++; if (PCPlus4_ID !== exp) begin n_fail++; $display("FAIL ar_pcp4 got %h want %h", PCPlus4_ID, exp); end
    exp = sb.pop_front(); n_cmp++; if (Valid_ID !== exp[0]) begin n_fail++; $display("FAIL ar_valid got %b want %b", Valid_ID, exp[0]); end
    exp = sb.pop_front(); n_cmp++; if (Ctrl_EX !== exp[11:0]) begin n_fail++; $display("FAIL ar_ctrl got %h want %h", Ctrl_EX, exp[11:0]); end
    exp = sb.pop_front(); n_cmp++; if (RT_EX !== exp[4:0]) begin n_fail++; $display("FAIL ar_rt got %0d want %0d", RT_EX, exp[4:0]); end
    exp = sb.pop_front(); n_cmp++; if (MemRead_EX !== exp[0]) begin n_fail++; $display("FAIL ar_memrd got %b want %b", MemRead_EX, exp[0]); end
    exp = sb.pop_front(); n_cmp++; if (StallCount !== exp[15:0]) begin n_fail++; $display("FAIL ar_cnt got %0d want %0d", StallCount, exp[15:0]); end
    exp = sb.pop_front(); n_cmp++; if (StallErr !== exp[0]) begin n_fail++; $display("FAIL ar_err got %b want %b", StallErr, exp[0]); end
    #1 reset = 1'b1;
    sb.push_back(32'd1); sb.push_back(32'h0040_0000); sb.push_back(32'h0);
    step();
    exp = sb.pop_front(); n_cmp++; if (StallCount !== exp[15:0]) begin n_fail++; $display("FAIL ar_post_cnt got %0d want %0d", StallCount, exp[15:0]); end
    exp = sb.pop_front(); n_cmp++; if (PC !== exp) begin n_fail++; $display("FAIL ar_post_pc got %h want %h", PC, exp); end
    exp = sb.pop_front(); n_cmp++; if (StallErr !== exp[0]) begin n_fail++; $display("FAIL ar_post_err got %b want %b", StallErr, exp[0]); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush();
    test_runaway();
    test_saturation();
    test_async_reset();
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL sb_drain got %0d leftover want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_front_ctrl.md
Name: pipe_front_ctrl

Overview:
- Front-end pipeline register block driven by the stall/bubble outputs of the load-use hazard detector.
- Holds the PC, the IF/ID register and the ID/EX control/RT register.
- Applies PC hold, IF/ID hold, bubble insertion and branch/jump flush, and feeds RT_EX/MemRead_EX back to the hazard detector.
- Also counts stall cycles and flags runaway stalls.

Parameters:
- N_BITS, 32, datapath width (PC, instruction).
- RESET_PC, 32'h0040_0000, PC value after reset.
- CTRL_W, 12, width of the ID/EX control bundle.
- MEMREAD_BIT, 3, index of the MemRead bit inside the control bundle.
- MAX_STALL, 4, maximum legal consecutive stall cycles before StallErr sets.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- PCWrite  input  1  1 = PC may load NextPC; 0 = hold.
- DWrite  input  1  1 = IF/ID may load; 0 = hold.
- Bubble  input  1  1 = insert all-zero control into ID/EX this cycle.
- Flush  input  1  taken branch/jump resolved in ID; squash the IF instruction.
- NextPC  input  N_BITS  next PC from the PC-select mux.
- Instruction_IF  input  N_BITS  instruction memory output.
- Ctrl_ID  input  CTRL_W  control bundle from the decoder.
- RT_ID  input  5  rt field of the instruction in ID.
- PC  output  N_BITS  current PC register.
- Instruction_ID  output  N_BITS  IF/ID instruction.
- PCPlus4_ID  output  N_BITS  IF/ID PC+4.
- Valid_ID  output  1  IF/ID holds a real instruction.
- Ctrl_EX  output  CTRL_W  ID/EX control bundle.
- RT_EX  output  5  ID/EX rt field.
- MemRead_EX  output  1  Ctrl_EX[MEMREAD_BIT], combinational from the register.
- StallCount  output  16  saturating count of stall cycles since reset.
- StallErr  output  1  sticky runaway-stall flag.

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - PC=RESET_PC; Instruction_ID=0; PCPlus4_ID=0; Valid_ID=0.
  - Ctrl_EX=0; RT_EX=0; StallCount=0; StallErr=0; FSM=RUN.
- All registers update on rising clk only. Every output is registered or a direct bit-select of a register, so response latency to each input is one cycle.
- PC register:
  - Flush=1: PC<=NextPC, regardless of PCWrite (redirect wins over stall).
  - Else PCWrite=1: PC<=NextPC.
  - Else hold.
- IF/ID register:
  - Flush=1: Instruction_ID<=0 (nop), PCPlus4_ID<=0, Valid_ID<=0. Flush wins over DWrite.
  - Else DWrite=1: Instruction_ID<=Instruction_IF, PCPlus4_ID<=PC+4 (modulo 2^N_BITS, wraps silently), Valid_ID<=1.
  - Else hold all three.
- ID/EX register:
  - Ctrl_EX<=0 if Bubble=1 or Valid_ID=0; otherwise Ctrl_EX<=Ctrl_ID.
  - RT_EX<=RT_ID every cycle, including bubbles. A bubbled RT_EX is harmless because MemRead_EX=0.
- Stall definition: stall cycle = Flush=0 and PCWrite=0.
- FSM RUN/STALL, with a 3-bit consecutive-stall counter run_cnt:
  - RUN: stall cycle -> STALL, run_cnt<=1. Otherwise stay in RUN, run_cnt<=0.
  - STALL: stall cycle -> stay, run_cnt<=run_cnt+1, saturating at 7. Non-stall cycle -> RUN, run_cnt<=0.
  - In STALL, when run_cnt reaches MAX_STALL and another stall cycle occurs, StallErr<=1. StallErr is sticky until reset.
- StallCount increments on every stall cycle and saturates at 16'hFFFF (no wrap).
- Inconsistent input PCWrite=1 with DWrite=0: the PC advances and IF/ID holds. This is not checked; the consistency of PCWrite/DWrite is the driver's responsibility.
- Simultaneous Flush and Bubble: the IF/ID squash and the ID/EX bubble both take effect in the same edge.

Test Plan:
- Reset release: hold reset=0, then release -> PC=32'h0040_0000, Valid_ID=0, Ctrl_EX=0; next edge with PCWrite=DWrite=1, NextPC=32'h0040_0004 -> PC=32'h0040_0004, Valid_ID=1, PCPlus4_ID=32'h0040_0004.
- Load-use stall: Ctrl_ID=12'h00A (MemRead bit set), PCWrite=DWrite=0, Bubble=1 for 1 cycle -> PC and Instruction_ID unchanged, Ctrl_EX=0, MemRead_EX=0, StallCount=1, FSM returns to RUN the next cycle.
- Flush during stall: PCWrite=0, DWrite=0, Flush=1, NextPC=32'h0040_0100 -> PC=32'h0040_0100, Instruction_ID=0, Valid_ID=0, StallCount unchanged; following cycle Ctrl_EX=0 even with Ctrl_ID nonzero.
- Runaway stall: PCWrite=0 for 5 consecutive cycles -> StallErr=1 after the 5th edge, StallCount=5; release and run 10 cycles -> StallErr still 1.
- Saturation: preload by running 65,540 stall cycles -> StallCount=16'hFFFF and holds; PC at 32'hFFFF_FFFC with DWrite=1 -> PCPlus4_ID=0.
- Async reset mid-stall: assert reset between clock edges while in STALL -> all outputs at reset values immediately, without waiting for clk.
